// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl
//   Sequences one external 4-bit adder slice to do a W-bit add or compare,
//   W = 4*NIBBLES, LSB nibble first, one nibble per clock.
//   Optional feature macro: SIGNED_CMP_EN (adds the sgn input for two's-complement compare).
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, op, a, b       : request handshake; op 0 = add, 1 = compare (a-b)
//   sgn                   : (SIGNED_CMP_EN only) signed compare select
//   busy, done            : busy in RUN/DONE; done is a one-cycle valid pulse
//   result, cout          : sum/difference and final carry out
//   gt, ls, eq            : compare flags, all 0 after an add
//   slice_a/b/cin         : operands and carry to the shared slice (0 unless RUN)
//   slice_sum/cout        : combinational response of the slice
module nibble_serial_alu_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
`ifdef SIGNED_CMP_EN
    input  logic                   sgn,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   gt,
    output logic                   ls,
    output logic                   eq,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic                   slice_cin,
    input  logic [3:0]             slice_sum,
    input  logic                   slice_cout
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic                      op_q, op_d;
    logic [NIBBLES-1:0][3:0]   a_q, a_d;
    logic [NIBBLES-1:0][3:0]   b_q, b_d;
    logic [NIBBLES-1:0][3:0]   result_q, result_d;
    logic                      cout_q, cout_d;
    logic                      gt_q, gt_d;
    logic                      ls_q, ls_d;
    logic                      eq_q, eq_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      sgn_q, sgn_d;

    logic [W-1:0]              final_c;
    logic                      last_c;
    logic                      ovf_c;

    // Full difference as it will stand once the MS nibble is written.
    assign final_c = {slice_sum, result_q[NIBBLES-2:0]};
    assign last_c  = (idx_q == IDX_W'(NIBBLES - 1));
    // Signed overflow: carry into the sign bit xor carry out of it.
    assign ovf_c   = slice_a[3] ^ slice_b[3] ^ slice_sum[3] ^ slice_cout;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            gt_q     <= 1'b0;
            ls_q     <= 1'b0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sgn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            gt_q     <= gt_d;
            ls_q     <= ls_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sgn_q    <= sgn_d;
        end
    end

    // Next-state, datapath and slice drive.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        cout_d    = cout_q;
        gt_d      = gt_q;
        ls_d      = ls_q;
        eq_d      = eq_q;
        sgn_d     = sgn_q;
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = op;
                    cout_d  = 1'b0;
                    gt_d    = 1'b0;
                    ls_d    = 1'b0;
                    eq_d    = 1'b0;
`ifdef SIGNED_CMP_EN
                    sgn_d   = sgn;
`else
                    sgn_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                slice_a         = a_q[idx_q];
                slice_b         = op_q ? ~b_q[idx_q] : b_q[idx_q];
                slice_cin       = carry_q;
                result_d[idx_q] = slice_sum;
                carry_d         = slice_cout;
                idx_d           = idx_q + IDX_W'(1);
                if (last_c) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    if (op_q) begin
                        eq_d = (final_c == '0);
                        if (sgn_q) begin
                            ls_d = slice_sum[3] ^ ovf_c;
                        end else begin
                            ls_d = ~slice_cout;
                        end
                        gt_d = ~ls_d & ~eq_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the upcoming state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign gt     = gt_q;
    assign ls     = ls_q;
    assign eq     = eq_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed testbench for nibble_serial_alu_ctrl (NIBBLES=4) with a
// behavioural 4-bit adder standing in for the shared slice.
module tb_nibble_serial_alu_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout;
    logic           gt;
    logic           ls;
    logic           eq;
    logic [3:0]     slice_a;
    logic [3:0]     slice_b;
    logic           slice_cin;
    logic [3:0]     slice_sum;
    logic           slice_cout;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int cyc_cnt = 0;

    logic [3:0] cin_log;
    int         lat;

    always #5 clk = ~clk;

    // Behavioural slice: combinational 4-bit adder.
    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    nibble_serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
`ifdef SIGNED_CMP_EN
        .sgn        (sgn),
`endif
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .gt         (gt),
        .ls         (ls),
        .eq         (eq),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst_n && start && !busy) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op and wait for done; leaves the bench at the negedge where done=1.
    task automatic run_op(input logic op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, input logic sgn_i);
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i; sgn = sgn_i;
        @(posedge clk); #1;
        start = 1'b0;
        cin_log = '0;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (c < 4) cin_log[c] = slice_cin;
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] r,
                                input logic c, input logic [2:0] f);
        check({tag, "_result"}, 32'(result), 32'(r));
        check({tag, "_cout"}, 32'(cout), 32'(c));
        check({tag, "_flags"}, 32'({gt, ls, eq}), 32'(f));
    endtask

    initial begin
        int d0;
        int t_done[3];
        int nd;
        logic prev_done;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; sgn = 1'b0;
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_result("rst", 16'h0000, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);

        // Add with carry ripple between nibbles.
        run_op(1'b0, 16'h1234, 16'h0FCC, 1'b0);
        check("add1_latency", 32'(lat), 32'd4);
        check("add1_busy", 32'(busy), 32'd1);
        check_result("add1", 16'h2200, 1'b0, 3'b000);
        check("done_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
        @(negedge clk);
        check("add1_done_width", 32'(done), 32'd0);
        check("add1_busy_off", 32'(busy), 32'd0);

        // Wraparound add: carry propagates into every upper nibble.
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        check_result("add2", 16'h0000, 1'b1, 3'b000);
        check("add2_cin", 32'(cin_log), 32'b1110);

        // Unsigned compares: {gt, ls, eq}.
        run_op(1'b1, 16'h0006, 16'h0008, 1'b0);
        check_result("cmp_lt", 16'hFFFE, 1'b0, 3'b010);
        check("cmp_lt_cin", 32'(cin_log), 32'b0001);
        run_op(1'b1, 16'h00AA, 16'h00AA, 1'b0);
        check_result("cmp_eq", 16'h0000, 1'b1, 3'b001);
        run_op(1'b1, 16'h0008, 16'h0006, 1'b0);
        check_result("cmp_gt", 16'h0002, 1'b1, 3'b100);
        run_op(1'b1, 16'hFFFF, 16'h0000, 1'b0);
        check_result("cmp_max", 16'hFFFF, 1'b1, 3'b100);
        run_op(1'b1, 16'h0000, 16'hFFFF, 1'b0);
        check_result("cmp_min", 16'h0001, 1'b0, 3'b010);
        // An add after a compare clears the flags.
        run_op(1'b0, 16'h1234, 16'h0FCC, 1'b0);
        check_result("add3", 16'h2200, 1'b0, 3'b000);

        // start during RUN is ignored.
        @(negedge clk);
        d0 = acc_cnt;
        start = 1'b1; op = 1'b0; a = 16'h0101; b = 16'h0202;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 16'hAAAA; b = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            if (done) begin lat = c; break; end
            @(negedge clk);
        end
        if (lat < 0) check("ign_timeout", 32'd0, 32'd1);
        check("ign_acc", 32'(acc_cnt - d0), 32'd1);
        check_result("ign", 16'h0303, 1'b0, 3'b000);
        @(negedge clk);

        // Reset during RUN at idx 2 aborts without done.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check_result("arst", 16'h0000, 1'b0, 3'b000);
        repeat (6) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);
        rst_n = 1'b1;
        run_op(1'b0, 16'h1111, 16'h2222, 1'b0);
        check("post_rst_latency", 32'(lat), 32'd4);
        check_result("post_rst", 16'h3333, 1'b0, 3'b000);
        @(negedge clk);

`ifdef SIGNED_CMP_EN
        run_op(1'b1, 16'h8000, 16'h0005, 1'b1);
        check_result("scmp", 16'h7FFB, 1'b1, 3'b010);
        run_op(1'b1, 16'h8000, 16'h0005, 1'b0);
        check_result("ucmp", 16'h7FFB, 1'b1, 3'b100);
        run_op(1'b0, 16'h8000, 16'h0005, 1'b1);
        check_result("sadd", 16'h8005, 1'b0, 3'b000);
        @(negedge clk);
`endif

        // Back-to-back with start held high: one op per NIBBLES+2 cycles.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h0F0F; b = 16'h0101;
        nd = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            @(negedge clk);
            if (done) begin
                if (prev_done) check("b2b_width", 32'd2, 32'd1);
                t_done[nd] = cyc_cnt;
                nd++;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("b2b_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("b2b_gap1", 32'(t_done[1] - t_done[0]), 32'd6);
            check("b2b_gap2", 32'(t_done[2] - t_done[1]), 32'd6);
        end
        @(negedge clk);
        check("b2b_width_end", 32'(done), 32'd0);
        check_result("b2b", 16'h1010, 1'b0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
